// File: rtl/rx_filt_sequencer_pkg.sv
// rtl/rx_filt_sequencer_pkg.sv - shared rx timing constants and sequencer state encoding
package rx_filt_sequencer_pkg;

  localparam int CLK_PER_SAM  = 4;
  localparam int SAM_PER_SYM  = 4;
  localparam int FILL_SAMPLES = 68;

  localparam int CLK_W  = $clog2(CLK_PER_SAM);
  localparam int SAM_W  = $clog2(SAM_PER_SYM);
  localparam int FILL_W = $clog2(FILL_SAMPLES + 1);
  localparam int SLIP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/rx_filt_sequencer_if.sv
// rtl/rx_filt_sequencer_if.sv - control and strobe bundle between the rx sequencer and its user
interface rx_filt_sequencer_if;
  import rx_filt_sequencer_pkg::*;

  logic              run;
  logic              sym_align;
  logic              sam_clk_en;
  logic              sym_clk_en;
  logic [CLK_W-1:0]  mac_phase;
  logic              y_valid;
  logic [SLIP_W-1:0] slip_cnt;

  modport master (
    output run, sym_align,
    input  sam_clk_en, sym_clk_en, mac_phase, y_valid, slip_cnt
  );

  modport slave (
    input  run, sym_align,
    output sam_clk_en, sym_clk_en, mac_phase, y_valid, slip_cnt
  );

endinterface

// File: rtl/rx_strobe_div.sv
// rtl/rx_strobe_div.sv - clock/sample divider producing sample and symbol strobes and MAC phase
module rx_strobe_div
  import rx_filt_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic             o_sam_en,
  output logic             o_sym_en,
  output logic [CLK_W-1:0] o_mac_phase
);

  logic [CLK_W-1:0] r_cnt_clk;
  logic [SAM_W-1:0] r_cnt_sam;
  logic             w_clk_wrap;
  logic             w_sam_wrap;

  assign w_clk_wrap = (r_cnt_clk == CLK_W'(CLK_PER_SAM - 1));
  assign w_sam_wrap = (r_cnt_sam == SAM_W'(SAM_PER_SYM - 1));

  // Clear wins over advance so a realign lands exactly on sample 0, phase 0.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt_clk <= '0;
      r_cnt_sam <= '0;
    end else if (i_en) begin
      if (w_clk_wrap) begin
        r_cnt_clk <= '0;
        r_cnt_sam <= w_sam_wrap ? '0 : r_cnt_sam + 1'b1;
      end else begin
        r_cnt_clk <= r_cnt_clk + 1'b1;
      end
    end
  end

  assign o_sam_en    = i_en & w_clk_wrap;
  assign o_sym_en    = o_sam_en & w_sam_wrap;
  assign o_mac_phase = r_cnt_clk;

endmodule

// File: rtl/rx_filt_sequencer.sv
// rtl/rx_filt_sequencer.sv - start-up/fill sequencer and symbol realignment for the rx shaping filter
module rx_filt_sequencer
  import rx_filt_sequencer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  rx_filt_sequencer_if.slave   io_rx
);

  state_e            r_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_y_valid;
  logic [SLIP_W-1:0] r_slip_cnt;

  logic              w_active;
  logic              w_align;
  logic              w_clr;
  logic              w_sam_en;
  logic              w_sym_en;
  logic [CLK_W-1:0]  w_mac_phase;

  assign w_active = (r_state != ST_IDLE);
  assign w_align  = w_active & io_rx.run & io_rx.sym_align;
  // Divider sits at zero throughout IDLE, on the way into IDLE, and after a realign pulse.
  assign w_clr    = ~w_active | ~io_rx.run | io_rx.sym_align;

  rx_strobe_div u_div (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (w_active),
    .i_clr       (w_clr),
    .o_sam_en    (w_sam_en),
    .o_sym_en    (w_sym_en),
    .o_mac_phase (w_mac_phase)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_fill_cnt <= '0;
      r_y_valid  <= 1'b0;
      r_slip_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fill_cnt <= '0;
          r_y_valid  <= 1'b0;
          if (io_rx.run) r_state <= ST_FILL;
        end
        ST_FILL: begin
          if (!io_rx.run) begin
            r_state    <= ST_IDLE;
            r_fill_cnt <= '0;
          end else if (w_sam_en) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            if (r_fill_cnt == FILL_W'(FILL_SAMPLES - 1)) begin
              r_state   <= ST_RUN;
              r_y_valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!io_rx.run) begin
            r_state    <= ST_IDLE;
            r_fill_cnt <= '0;
            r_y_valid  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_fill_cnt <= '0;
          r_y_valid  <= 1'b0;
        end
      endcase

      // A pulse on a natural symbol boundary does not move the phase, so it is not a slip.
      if (w_align && !w_sym_en && (r_slip_cnt != {SLIP_W{1'b1}}))
        r_slip_cnt <= r_slip_cnt + 1'b1;
    end
  end

  assign io_rx.sam_clk_en = w_sam_en;
  assign io_rx.sym_clk_en = w_sym_en;
  assign io_rx.mac_phase  = w_mac_phase;
  assign io_rx.y_valid    = r_y_valid;
  assign io_rx.slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_rx_filt_sequencer.sv
// tb/tb_rx_filt_sequencer.sv - directed self-checking bench for rx_filt_sequencer
module tb_rx_filt_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   c;
  int   base;
  int   yv_from;
  int   exp_slip;

  rx_filt_sequencer_if bus ();

  rx_filt_sequencer dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_rx   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d cycle=%0d", tag, obs, exp, c);
    end
  endtask

  // One clock of FILL/RUN; base is the cycle holding sample 0, phase 0.
  task automatic cyc(input bit align);
    bit was_sym;
    was_sym = align && (((c - base) % 16) == 15);
    bus.sym_align = align;
    @(posedge clk); #1;
    bus.sym_align = 1'b0;
    c++;
    if (align) begin
      base = c;
      if (!was_sym && exp_slip < 255) exp_slip++;
    end
    chk("sam_clk_en", int'(bus.sam_clk_en), int'(((c - base) % 4) == 3));
    chk("sym_clk_en", int'(bus.sym_clk_en), int'(((c - base) % 16) == 15));
    chk("mac_phase",  int'(bus.mac_phase),  (c - base) % 4);
    chk("y_valid",    int'(bus.y_valid),    int'(c >= yv_from));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_sam"},   int'(bus.sam_clk_en), 0);
    chk({tag, "_sym"},   int'(bus.sym_clk_en), 0);
    chk({tag, "_phase"}, int'(bus.mac_phase),  0);
    chk({tag, "_yv"},    int'(bus.y_valid),    0);
  endtask

  task automatic restart_model(input int yv_at);
    c       = 0;
    base    = 1;
    yv_from = yv_at;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_slip = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.sym_align = 1'b0;
    restart_model(273);
    repeat (3) @(posedge clk);
    #1;
    idle_chk("reset");
    chk("reset_slip", int'(bus.slip_cnt), 0);

    // Fill from run rise: 68 strobes by cycle 272, y_valid from 273.
    reset = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 300; i++) cyc(1'b0);

    // Realign 6 clk after the symbol strobe at cycle 304.
    for (int i = 0; i < 10; i++) cyc(1'b0);
    cyc(1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0);
    chk("slip_after_align", int'(bus.slip_cnt), 1);

    // Pulse exactly on a symbol strobe: phase and slip unchanged.
    for (int i = 0; i < 16 && (((c - base) % 16) != 15); i++) cyc(1'b0);
    chk("at_sym_boundary", int'(bus.sym_clk_en), 1);
    cyc(1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0);
    chk("slip_coincident", int'(bus.slip_cnt), 1);

    // One-cycle run drop, then a complete refill.
    bus.run = 1'b0;
    @(posedge clk); #1;
    idle_chk("drop");
    bus.run = 1'b1;
    restart_model(273);
    for (int i = 0; i < 280; i++) cyc(1'b0);

    // Second drop, then reset partway through FILL.
    bus.run = 1'b0;
    @(posedge clk); #1;
    idle_chk("drop2");
    bus.run = 1'b1;
    restart_model(273);
    for (int i = 0; i < 100; i++) cyc(1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    idle_chk("mid_reset");
    chk("mid_reset_slip", int'(bus.slip_cnt), 0);
    exp_slip = 0;
    reset = 1'b0;
    restart_model(1000000);
    cyc(1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1);
    chk("slip_saturated", int'(bus.slip_cnt), 255);
    chk("slip_model", int'(bus.slip_cnt), exp_slip);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
